uart_tx_arbiter: RTL and testbench

//   Shares the SoC's single UART transmitter between two byte-stream requesters:

---
 rtl/uart_tx_arbiter.sv | 158 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Purpose : shares one UART transmitter between the CPU (port 0) and the debug/log source (port 1),
//           round-robin at packet granularity, with the grant revoked from an owner idle too long.
// Latency : valid seen in IDLE -> ready on the next cycle -> tx_start the cycle after (2 cycles).
// Backpressure: only the owner sees ready, and only in GRANT; ready stays low while a byte is in flight.
//
// Optional feature macro: UART_ARB_STATS_EN adds saturating per-requester byte counters cnt0/cnt1.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   reqN_valid/data/last/ready    byte-stream requesters (N = 0 CPU, 1 debug)
//   tx_start, tx_data, tx_busy    uart tx core interface (tx_data held until tx_busy falls)
//   grant                         one-hot current owner, 2'b00 when idle
//   timeout                       one-cycle pulse when an idle owner loses its grant
//   cnt0, cnt1                    bytes sent per requester (UART_ARB_STATS_EN only)
module uart_tx_arbiter #(
    parameter int TIMEOUT_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 40000
`ifdef UART_ARB_STATS_EN
    ,
    parameter int STATS_WIDTH    = 16
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic [1:0] grant,
    output logic       timeout
`ifdef UART_ARB_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0] cnt0,
    output logic [STATS_WIDTH-1:0] cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SEND  = 2'd2,
        WAIT  = 2'd3
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                   state;
    logic                     owner;       // 0 = requester 0, 1 = requester 1
    logic                     last_owner;  // owner of the most recently finished/revoked grant
    logic                     last_flag;   // captured byte closes its packet
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt;

    logic       owner_valid;
    logic [7:0] owner_data;
    logic       owner_last;

    assign owner_valid = owner ? req1_valid : req0_valid;
    assign owner_data  = owner ? req1_data  : req0_data;
    assign owner_last  = owner ? req1_last  : req0_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            last_flag  <= 1'b0;
            tmo_cnt    <= '0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            grant      <= 2'b00;
            timeout    <= 1'b0;
`ifdef UART_ARB_STATS_EN
            cnt0       <= '0;
            cnt1       <= '0;
`endif
        end else begin
            tx_start <= 1'b0;
            timeout  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        // On a tie the requester that did not own the last grant wins.
                        if (req0_valid && (!req1_valid || last_owner)) begin
                            owner      <= 1'b0;
                            grant      <= 2'b01;
                            req0_ready <= 1'b1;
                        end else begin
                            owner      <= 1'b1;
                            grant      <= 2'b10;
                            req1_ready <= 1'b1;
                        end
                        tmo_cnt <= '0;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (owner_valid) begin
                        // Owner handshake: ready is already high throughout GRANT.
                        tx_data    <= owner_data;
                        last_flag  <= owner_last;
                        tmo_cnt    <= '0;
                        req0_ready <= 1'b0;
                        req1_ready <= 1'b0;
                        tx_start   <= 1'b1;
                        state      <= SEND;
`ifdef UART_ARB_STATS_EN
                        if (!owner && (cnt0 != '1)) cnt0 <= cnt0 + STATS_WIDTH'(1);
                        if (owner && (cnt1 != '1))  cnt1 <= cnt1 + STATS_WIDTH'(1);
`endif
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Stalled owner: revoke, and count it as the last owner so the
                        // other requester wins the next tie.
                        timeout    <= 1'b1;
                        last_owner <= owner;
                        grant      <= 2'b00;
                        req0_ready <= 1'b0;
                        req1_ready <= 1'b0;
                        tmo_cnt    <= '0;
                        state      <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TIMEOUT_WIDTH'(1);
                    end
                end
                SEND: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (!tx_busy) begin
                        if (last_flag) begin
                            last_owner <= owner;
                            grant      <= 2'b00;
                            state      <= IDLE;
                        end else begin
                            // Mid-packet: keep the grant, reopen the owner's ready.
                            req0_ready <= ~owner;
                            req1_ready <= owner;
                            tmo_cnt    <= '0;
                            state      <= GRANT;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int TMO = 8;

    logic       clk;
    logic       reset_n;
    logic       req0_valid, req0_last, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] req1_data;
    logic       tx_start, tx_busy, timeout;
    logic [7:0] tx_data;
    logic [1:0] grant;
`ifdef UART_ARB_STATS_EN
    logic [3:0] cnt0, cnt1;
`endif

    uart_tx_arbiter #(
        .TIMEOUT_WIDTH (4),
        .TIMEOUT_CYCLES(TMO)
`ifdef UART_ARB_STATS_EN
        ,
        .STATS_WIDTH   (4)
`endif
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_last (req0_last),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_last (req1_last),
        .req1_ready(req1_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .grant     (grant),
        .timeout   (timeout)
`ifdef UART_ARB_STATS_EN
        ,
        .cnt0      (cnt0),
        .cnt1      (cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Requester byte queues, entries are {last, data}.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [7:0] log_dat[$];
    logic [1:0] log_gnt[$];
    int cyc       = 0;
    int busy_len  = 3;
    int busy_left = 0;
    int n_tmo     = 0;
    int tmo_cyc   = 0;
    int rise1     = 0;
    logic prev_rdy1 = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] log_d(input int i);
        return (i < log_dat.size()) ? {24'h0, log_dat[i]} : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] log_g(input int i);
        return (i < log_gnt.size()) ? {30'h0, log_gnt[i]} : 32'hxxxx_xxxx;
    endfunction

    task automatic drive();
        req0_valid = (q0.size() != 0);
        {req0_last, req0_data} = (q0.size() != 0) ? q0[0] : 9'h000;
        req1_valid = (q1.size() != 0);
        {req1_last, req1_data} = (q1.size() != 0) ? q1[0] : 9'h000;
    endtask

    // One clock cycle: handshakes are judged on pre-edge values, the uart core
    // model and event logs are updated 1 ns after the edge.
    task automatic tick();
        logic hs0, hs1;
        hs0 = req0_valid & req0_ready;
        hs1 = req1_valid & req1_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (hs0) q0.delete(0);
        if (hs1) q1.delete(0);
        drive();
        tx_busy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
        if (tx_start) begin
            log_dat.push_back(tx_data);
            log_gnt.push_back(grant);
            busy_left = busy_len;
        end
        if (timeout) begin
            n_tmo++;
            tmo_cyc = cyc;
        end
        if (req1_ready && !prev_rdy1) rise1 = cyc;
        prev_rdy1 = req1_ready;
    endtask

    task automatic run_until_idle(input string tag, input int max);
        bit done = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && grant == 2'b00 &&
                busy_left == 0 && !tx_busy) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, {31'h0, done}, 32'h1);
    endtask

    task automatic wait_log(input string tag, input int n, input int max);
        for (int i = 0; i < max; i++) begin
            if (log_dat.size() >= n) break;
            tick();
        end
        chk(tag, (log_dat.size() >= n) ? 32'h1 : 32'h0, 32'h1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        q0.delete();
        q1.delete();
        drive();
        busy_left = 0;
        tx_busy   = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    logic [7:0] exp_d[6];
    logic [1:0] exp_g[6];

    initial begin
        reset_n = 1'b0;
        tx_busy = 1'b0;
        drive();
        #12;
        // Reset state.
        chk("rst_ready0", {31'h0, req0_ready}, 32'h0);
        chk("rst_ready1", {31'h0, req1_ready}, 32'h0);
        chk("rst_tx_start", {31'h0, tx_start}, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
        chk("rst_grant", {30'h0, grant}, 32'h0);
        chk("rst_timeout", {31'h0, timeout}, 32'h0);
        do_reset();

        // Latency and single packet from req0, 10 busy cycles per byte.
        busy_len = 10;
        log_dat.delete();
        log_gnt.delete();
        q0.push_back({1'b0, 8'h41});
        q0.push_back({1'b0, 8'h42});
        q0.push_back({1'b1, 8'h43});
        drive();                                   // cycle N: valid rises in IDLE
        chk("lat_n_ready", {31'h0, req0_ready}, 32'h0);
        tick();                                    // N+1
        chk("lat_n1_ready", {31'h0, req0_ready}, 32'h1);
        chk("lat_n1_grant", {30'h0, grant}, 32'h1);
        chk("lat_n1_start", {31'h0, tx_start}, 32'h0);
        tick();                                    // N+2
        chk("lat_n2_start", {31'h0, tx_start}, 32'h1);
        chk("lat_n2_data", {24'h0, tx_data}, 32'h41);
        chk("lat_n2_ready", {31'h0, req0_ready}, 32'h0);
        tick();
        chk("pulse_one_cycle", {31'h0, tx_start}, 32'h0);
        repeat (5) tick();
        chk("wait_grant_held", {30'h0, grant}, 32'h1);
        chk("wait_data_held", {24'h0, tx_data}, 32'h41);
        chk("wait_ready_low", {31'h0, req0_ready}, 32'h0);
        run_until_idle("pkt_drain", 200);
        chk("pkt_count", log_dat.size(), 32'd3);
        chk("pkt_d0", log_d(0), 32'h41);
        chk("pkt_d1", log_d(1), 32'h42);
        chk("pkt_d2", log_d(2), 32'h43);
        chk("pkt_g0", log_g(0), 32'h1);
        chk("pkt_g1", log_g(1), 32'h1);
        chk("pkt_g2", log_g(2), 32'h1);
        chk("pkt_end_grant", {30'h0, grant}, 32'h0);

        // Reset in the middle of WAIT.
        log_dat.delete();
        log_gnt.delete();
        q1.push_back({1'b0, 8'h55});
        q1.push_back({1'b1, 8'h56});
        drive();
        wait_log("mid_first_byte", 1, 20);
        repeat (3) tick();
        chk("mid_pre_grant", {30'h0, grant}, 32'h2);
        chk("mid_pre_data", {24'h0, tx_data}, 32'h55);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_grant", {30'h0, grant}, 32'h0);
        chk("mid_rst_data", {24'h0, tx_data}, 32'h0);
        chk("mid_rst_ready1", {31'h0, req1_ready}, 32'h0);
        chk("mid_rst_start", {31'h0, tx_start}, 32'h0);
        do_reset();

        // Tie after reset, then round-robin between packets.
        busy_len = 3;
        log_dat.delete();
        log_gnt.delete();
        q0.push_back({1'b0, 8'hA0});
        q0.push_back({1'b1, 8'hA1});
        q0.push_back({1'b0, 8'hA2});
        q0.push_back({1'b1, 8'hA3});
        q1.push_back({1'b0, 8'hB0});
        q1.push_back({1'b1, 8'hB1});
        drive();
        run_until_idle("tie_drain", 400);
        exp_d = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA2, 8'hA3};
        exp_g = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
        chk("tie_count", log_dat.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("tie_d%0d", i), log_d(i), {24'h0, exp_d[i]});
            chk($sformatf("tie_g%0d", i), log_g(i), {30'h0, exp_g[i]});
        end

        // Timeout: req1 sends one byte without last, then stalls while req0 waits.
        log_dat.delete();
        log_gnt.delete();
        n_tmo = 0;
        q1.push_back({1'b0, 8'hC0});
        drive();
        wait_log("tmo_first_byte", 1, 20);
        q0.push_back({1'b1, 8'hD0});
        drive();
        for (int i = 0; i < 60; i++) begin
            if (n_tmo != 0) break;
            tick();
        end
        chk("tmo_seen", n_tmo, 32'd1);
        chk("tmo_delay", tmo_cyc - rise1, TMO);
        chk("tmo_grant_idle", {30'h0, grant}, 32'h0);
        chk("tmo_ready0_low", {31'h0, req0_ready}, 32'h0);
        tick();
        chk("tmo_pulse_width", {31'h0, timeout}, 32'h0);
        chk("tmo_next_grant", {30'h0, grant}, 32'h1);
        chk("tmo_next_ready0", {31'h0, req0_ready}, 32'h1);
        run_until_idle("tmo_drain", 100);
        chk("tmo_count", log_dat.size(), 32'd2);
        chk("tmo_d1", log_d(1), 32'hD0);
        chk("tmo_g1", log_g(1), 32'h1);
        chk("tmo_once", n_tmo, 32'd1);

`ifdef UART_ARB_STATS_EN
        // Saturating byte counters.
        do_reset();
        chk("stats_rst_cnt0", {28'h0, cnt0}, 32'h0);
        chk("stats_rst_cnt1", {28'h0, cnt1}, 32'h0);
        busy_len = 2;
        for (int i = 0; i < 20; i++) q1.push_back({(i == 19), 8'(i)});
        drive();
        run_until_idle("stats_drain", 600);
        chk("stats_cnt1", {28'h0, cnt1}, 32'd15);
        chk("stats_cnt0", {28'h0, cnt0}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
